// File: rtl/snake_motion_if.sv
// Control, status and segment-readout signals of the snake game-step engine.
// The master drives direction/pulses/readout select; the slave is the engine.
interface snake_motion_if;
  logic [1:0] dir;
  logic       grow;
  logic       restart;
  logic [3:0] seg_sel;
  logic       tick;
  logic [4:0] headX;
  logic [4:0] headY;
  logic [4:0] length;
  logic [4:0] segX;
  logic [4:0] segY;
  logic       segValid;
  logic       gameOver;

  modport master (
    output dir, grow, restart, seg_sel,
    input  tick, headX, headY, length, segX, segY, segValid, gameOver
  );

  modport slave (
    input  dir, grow, restart, seg_sel,
    output tick, headX, headY, length, segX, segY, segValid, gameOver
  );
endinterface

// File: rtl/snake_motion.sv
// Snake game-step engine: divides the clock into game ticks, shifts the body
// one cell per tick, and detects wall/self collisions (RUN -> DEAD).
module snake_motion #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int TICK_DIV = 10_000_000,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input logic          CLK_100MHz,
  input logic          Reset_n,
  snake_motion_if.slave bus
);
  localparam int             CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST    = CW'(TICK_DIV - 1);
  localparam logic [4:0]     LEN_MAX = 5'(MAX_LEN);

  typedef enum logic {RUN, DEAD} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          tick_reg;
  logic          pend_reg;
  logic          over_reg;
  logic [4:0]    len_reg;

  logic [4:0] seg_x [MAX_LEN];
  logic [4:0] seg_y [MAX_LEN];

  logic       step;
  logic       grow_eff;
  logic       wall;
  logic       hit;
  logic       advance;
  logic [4:0] hx, hy, nx, ny, lim;

  assign hx       = seg_x[0];
  assign hy       = seg_y[0];
  assign step     = (state_reg == RUN) && (cnt_reg == LAST);
  assign cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
  // A grow pulse landing on the step cycle counts for that step.
  assign grow_eff = (pend_reg | bus.grow) && (len_reg < LEN_MAX);
  assign lim      = len_reg - 5'd1 + {4'd0, grow_eff};
  assign advance  = step && !hit && !bus.restart;

  always_comb begin
    nx   = hx;
    ny   = hy;
    wall = 1'b0;
    case (bus.dir)
      2'b00: begin wall = (hy == 5'd0);             ny = hy - 5'd1; end
      2'b01: begin wall = (hx == 5'(GRID_W - 1));   nx = hx + 5'd1; end
      2'b10: begin wall = (hy == 5'(GRID_H - 1));   ny = hy + 5'd1; end
      default: begin wall = (hx == 5'd0);           nx = hx - 5'd1; end
    endcase
  end

  // The tail cell is only excluded when it actually vacates this step.
  always_comb begin
    hit = wall;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < lim) && (seg_x[i] == nx) && (seg_y[i] == ny)) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      tick_reg  <= 1'b0;
      pend_reg  <= 1'b0;
      over_reg  <= 1'b0;
      len_reg   <= 5'(INIT_LEN);
    end else if (bus.restart) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      tick_reg  <= 1'b0;
      pend_reg  <= 1'b0;
      over_reg  <= 1'b0;
      len_reg   <= 5'(INIT_LEN);
    end else if (state_reg == RUN) begin
      cnt_reg <= cnt_next;
      if (step && hit) begin
        state_reg <= DEAD;
        over_reg  <= 1'b1;
        tick_reg  <= 1'b0;
      end else begin
        tick_reg <= (cnt_next == LAST);
        if (step) begin
          pend_reg <= 1'b0;
          if (grow_eff) begin
            len_reg <= len_reg + 5'd1;
          end
        end else if (bus.grow) begin
          pend_reg <= 1'b1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : seg_g
      localparam logic [4:0] IX = (gi < INIT_LEN) ? 5'(START_X) : 5'd0;
      localparam logic [4:0] IY = (gi < INIT_LEN) ? 5'(START_Y + gi) : 5'd0;
      logic [4:0] x_reg;
      logic [4:0] y_reg;

      always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
          x_reg <= IX;
          y_reg <= IY;
        end else if (bus.restart) begin
          x_reg <= IX;
          y_reg <= IY;
        end else if (advance) begin
          if (gi == 0) begin
            x_reg <= nx;
            y_reg <= ny;
          end else begin
            x_reg <= seg_x[(gi == 0) ? 0 : gi - 1];
            y_reg <= seg_y[(gi == 0) ? 0 : gi - 1];
          end
        end
      end

      assign seg_x[gi] = x_reg;
      assign seg_y[gi] = y_reg;
    end
  endgenerate

  assign bus.tick     = tick_reg;
  assign bus.headX    = hx;
  assign bus.headY    = hy;
  assign bus.length   = len_reg;
  assign bus.gameOver = over_reg;
  assign bus.segValid = ({1'b0, bus.seg_sel} < len_reg);
  assign bus.segX     = (int'(bus.seg_sel) < MAX_LEN) ? seg_x[bus.seg_sel] : 5'd0;
  assign bus.segY     = (int'(bus.seg_sel) < MAX_LEN) ? seg_y[bus.seg_sel] : 5'd0;
endmodule

// File: tb/tb_snake_motion.sv
// Bench for snake_motion: directed scenarios plus random play, checked against
// a queue-based model of the snake body.
module tb_snake_motion;
  localparam int TD   = 4;
  localparam int MAXL = 16;
  localparam int IL   = 4;
  localparam int SX   = 16;
  localparam int SY   = 12;
  localparam int GW   = 32;
  localparam int GH   = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  snake_motion_if bus();

  snake_motion #(
    .GRID_W(GW), .GRID_H(GH), .TICK_DIV(TD), .MAX_LEN(MAXL),
    .INIT_LEN(IL), .START_X(SX), .START_Y(SY)
  ) dut (
    .CLK_100MHz(clk),
    .Reset_n(rst_n),
    .bus(bus)
  );

  always #50 clk = ~clk;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } cell_t;

  cell_t body[$];
  bit    alive;
  bit    pend;
  int    cnt;
  int    nsteps = 0;
  int    total  = 0;
  int    bad    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    body.delete();
    for (int i = 0; i < IL; i++) body.push_back(cell_t'{5'(SX), 5'(SY + i)});
    alive = 1'b1;
    pend  = 1'b0;
    cnt   = 0;
  endfunction

  // Model effect of one clock edge with the given inputs.
  task automatic model_edge(input logic [1:0] d, input bit g, input bit r);
    bit growing;
    bit hit;
    int hx, hy, nx, ny, lim;
    if (r) begin
      model_reset();
    end else if (alive) begin
      if (cnt == TD - 1) begin
        growing = (pend || g) && (body.size() < MAXL);
        hx = body[0].x; hy = body[0].y; nx = hx; ny = hy;
        case (d)
          2'd0: begin hit = (hy == 0);      ny = hy - 1; end
          2'd1: begin hit = (hx == GW - 1); nx = hx + 1; end
          2'd2: begin hit = (hy == GH - 1); ny = hy + 1; end
          default: begin hit = (hx == 0);   nx = hx - 1; end
        endcase
        lim = growing ? body.size() : body.size() - 1;
        for (int i = 0; i < lim; i++)
          if (body[i].x == nx && body[i].y == ny) hit = 1'b1;
        if (hit) begin
          alive = 1'b0;
        end else begin
          body.push_front(cell_t'{5'(nx), 5'(ny)});
          if (!growing) void'(body.pop_back());
          pend = 1'b0;
        end
        cnt = 0;
        nsteps++;
        $display("step %0d dir=%0d grow=%0b head=(%0d,%0d) len=%0d alive=%0b",
                 nsteps, d, g, body[0].x, body[0].y, body.size(), alive);
      end else begin
        cnt++;
        if (g) pend = 1'b1;
      end
    end
  endtask

  task automatic check_outs();
    check("tick",     bus.tick,     32'(alive && cnt == TD - 1));
    check("headX",    bus.headX,    32'(body[0].x));
    check("headY",    bus.headY,    32'(body[0].y));
    check("length",   bus.length,   32'(body.size()));
    check("gameOver", bus.gameOver, 32'(!alive));
  endtask

  task automatic check_segs();
    for (int s = 0; s < 16; s++) begin
      bus.seg_sel = 4'(s);
      #1;
      check("segValid", bus.segValid, 32'(s < body.size()));
      if (s < body.size()) begin
        check("segX", bus.segX, 32'(body[s].x));
        check("segY", bus.segY, 32'(body[s].y));
      end
    end
    bus.seg_sel = 4'd0;
  endtask

  // Called at a negedge: drive inputs, cross one rising edge, check outputs.
  task automatic cycle(input logic [1:0] d, input bit g, input bit r);
    bus.dir     = d;
    bus.grow    = g;
    bus.restart = r;
    model_edge(d, g, r);
    @(posedge clk);
    @(negedge clk);
    bus.grow    = 1'b0;
    bus.restart = 1'b0;
    check_outs();
  endtask

  task automatic run_steps(input int n, input logic [1:0] d, input bit grow_on_step);
    int done = 0;
    bit st;
    for (int c = 0; c < n * TD + TD && done < n; c++) begin
      st = alive && (cnt == TD - 1);
      cycle(d, grow_on_step && st, 1'b0);
      if (st) done++;
    end
  endtask

  initial begin
    bus.dir = 2'd0; bus.grow = 1'b0; bus.restart = 1'b0; bus.seg_sel = 4'd0;
    model_reset();
    #220;
    @(negedge clk);
    check_outs();
    rst_n = 1'b1;
    #1;
    check_outs();
    check("rst_headX", bus.headX, 32'd16);
    check("rst_headY", bus.headY, 32'd12);
    check("rst_len",   bus.length, 32'd4);
    check_segs();

    // Move up three ticks.
    run_steps(3, 2'd0, 1'b0);
    check("up3_headY", bus.headY, 32'd9);
    check_segs();

    // Hit the top wall, then dir changes must do nothing.
    run_steps(20, 2'd0, 1'b0);
    for (int c = 0; c < 8; c++) cycle(2'(c), 1'b0, 1'b0);
    check("wall_over",  bus.gameOver, 32'd1);
    check("wall_headY", bus.headY,    32'd0);

    // Restart from DEAD.
    cycle(2'd0, 1'b0, 1'b1);
    check("rs_over", bus.gameOver, 32'd0);
    check("rs_len",  bus.length,   32'd4);
    check_segs();

    // Grow then curl back onto the retained tail.
    cycle(2'd0, 1'b1, 1'b0);
    run_steps(1, 2'd1, 1'b0);
    check("grow_len",   bus.length, 32'd5);
    check("grow_headX", bus.headX,  32'd17);
    check_segs();
    run_steps(1, 2'd2, 1'b0);
    run_steps(1, 2'd3, 1'b0);
    check("self_over", bus.gameOver, 32'd1);

    // Same path without grow: the tail vacates.
    cycle(2'd0, 1'b0, 1'b1);
    run_steps(1, 2'd1, 1'b0);
    run_steps(1, 2'd2, 1'b0);
    run_steps(1, 2'd3, 1'b0);
    check("noself_over",  bus.gameOver, 32'd0);
    check("noself_headX", bus.headX,    32'd16);
    check("noself_headY", bus.headY,    32'd13);

    // Grow to the cap with grow pulses coincident with ticks.
    cycle(2'd0, 1'b0, 1'b1);
    run_steps(14, 2'd1, 1'b1);
    check("max_len", bus.length, 32'd16);
    check_segs();

    // Asynchronous reset asserted during a step cycle.
    cycle(2'd0, 1'b0, 1'b1);
    for (int c = 0; c < 2 * TD && !(cnt == TD - 1); c++) cycle(2'd1, 1'b0, 1'b0);
    check("pre_async_tick", bus.tick, 32'd1);
    #5;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outs();

    // Random play.
    for (int c = 0; c < 600; c++) begin
      logic [1:0] d;
      bit g, r;
      d = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : bus.dir;
      g = ($urandom_range(7) == 0);
      r = (!alive && $urandom_range(3) == 0) || ($urandom_range(99) == 0);
      cycle(d, g, r);
      if (c % 50 == 0) check_segs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
